// File: rtl/stream_mcast_xbar.sv
// Multicast stream crossbar: every input beat is delivered to all outputs
// selected by its mask before the input handshake completes. Each output has
// a round-robin arbiter with lock-in and an optional output FIFO.
module stream_mcast_xbar #(
  parameter int unsigned NumInp       = 2,
  parameter int unsigned NumOut       = 2,
  parameter int unsigned DataWidth    = 32,
  parameter type         payload_t    = logic [DataWidth-1:0],
  parameter int unsigned OutFifoDepth = 0,
  parameter int unsigned IdxWidth     = (NumInp > 1) ? $clog2(NumInp) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  payload_t [NumInp-1:0]               data_i,
  input  logic     [NumInp-1:0][NumOut-1:0]   mask_i,
  input  logic     [NumInp-1:0]               valid_i,
  output logic     [NumInp-1:0]               ready_o,
  output payload_t [NumOut-1:0]               data_o,
  output logic     [NumOut-1:0][IdxWidth-1:0] idx_o,
  output logic     [NumOut-1:0]               valid_o,
  input  logic     [NumOut-1:0]               ready_i
);

  // take_w[j][i]: output j accepts input i's current beat this cycle
  logic [NumInp-1:0]             take_w [NumOut];
  // served_q[i][j]: output j already holds input i's current beat
  logic [NumInp-1:0][NumOut-1:0] served_q, served_d;

  // An input completes once every selected output has taken (or is taking) its beat
  always_comb begin
    ready_o = valid_i;
    for (int i = 0; i < NumInp; i++) begin
      for (int j = 0; j < NumOut; j++) begin
        if (mask_i[i][j] && !served_q[i][j] && !take_w[j][i]) ready_o[i] = 1'b0;
      end
    end
  end

  // Mark new deliveries; a completed input clears its whole row
  always_comb begin
    served_d = served_q;
    for (int i = 0; i < NumInp; i++) begin
      for (int j = 0; j < NumOut; j++) begin
        if (take_w[j][i]) served_d[i][j] = 1'b1;
      end
      if (ready_o[i]) served_d[i] = '0;
    end
  end

  // Served bookkeeping register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        served_q <= '0;
    else if (flush_i) served_q <= '0;
    else              served_q <= served_d;
  end

  for (genvar j = 0; j < NumOut; j++) begin : g_out
    logic [NumInp-1:0]   req;
    logic [IdxWidth-1:0] ptr_q, ptr_d, lock_idx_q, lock_idx_d, sel;
    logic                lock_q, lock_d, arb_valid, arb_ready, hs;

    // Pending requests towards this output
    always_comb begin
      req = '0;
      for (int i = 0; i < NumInp; i++) begin
        req[i] = valid_i[i] & mask_i[i][j] & ~served_q[i][j];
      end
    end

    // Round-robin pick starting at the pointer; a locked choice is held
    always_comb begin
      logic [IdxWidth-1:0] cand;
      int unsigned         cnd;
      logic                found;
      cand  = '0;
      cnd   = 0;
      found = 1'b0;
      sel   = '0;
      if (lock_q) begin
        sel   = lock_idx_q;
        found = req[lock_idx_q];
      end else begin
        for (int unsigned k = 0; k < NumInp; k++) begin
          cnd  = (32'(ptr_q) + k) % NumInp;
          cand = IdxWidth'(cnd);
          if (!found && req[cand]) begin
            found = 1'b1;
            sel   = cand;
          end
        end
      end
      arb_valid = found;
    end

    assign hs = arb_valid & arb_ready;

    // Handshake bookkeeping: take vector, pointer advance and lock-in
    always_comb begin
      for (int i = 0; i < NumInp; i++) begin
        take_w[j][i] = hs && (sel == IdxWidth'(i));
      end
      ptr_d = ptr_q;
      if (hs) ptr_d = (sel == IdxWidth'(NumInp - 1)) ? '0 : sel + 1'b1;
      lock_d     = arb_valid & ~arb_ready;
      lock_idx_d = lock_d ? sel : lock_idx_q;
    end

    // Arbiter state register
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        ptr_q      <= '0;
        lock_q     <= 1'b0;
        lock_idx_q <= '0;
      end else if (flush_i) begin
        ptr_q      <= '0;
        lock_q     <= 1'b0;
        lock_idx_q <= '0;
      end else begin
        ptr_q      <= ptr_d;
        lock_q     <= lock_d;
        lock_idx_q <= lock_idx_d;
      end
    end

    if (OutFifoDepth == 0) begin : g_bypass
      assign arb_ready  = ready_i[j];
      assign valid_o[j] = arb_valid;
      assign data_o[j]  = arb_valid ? data_i[sel] : '0;
      assign idx_o[j]   = arb_valid ? sel : '0;
    end else begin : g_fifo
      localparam int unsigned PtrW = (OutFifoDepth > 1) ? $clog2(OutFifoDepth) : 1;
      localparam int unsigned CntW = $clog2(OutFifoDepth + 1);

      payload_t            mem_q     [OutFifoDepth];
      logic [IdxWidth-1:0] idx_mem_q [OutFifoDepth];
      logic [PtrW-1:0]     wr_q, rd_q;
      logic [CntW-1:0]     cnt_q;
      logic                full, pop;

      // A full FIFO still accepts when it is popped in the same cycle
      assign full       = (cnt_q == CntW'(OutFifoDepth));
      assign pop        = valid_o[j] & ready_i[j];
      assign arb_ready  = ~full | pop;
      assign valid_o[j] = (cnt_q != '0);
      assign data_o[j]  = valid_o[j] ? mem_q[rd_q] : '0;
      assign idx_o[j]   = valid_o[j] ? idx_mem_q[rd_q] : '0;

      // FIFO pointers and occupancy; flush wins over a simultaneous push
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          wr_q  <= '0;
          rd_q  <= '0;
          cnt_q <= '0;
        end else if (flush_i) begin
          wr_q  <= '0;
          rd_q  <= '0;
          cnt_q <= '0;
        end else begin
          if (hs)  wr_q <= (wr_q == PtrW'(OutFifoDepth - 1)) ? '0 : wr_q + 1'b1;
          if (pop) rd_q <= (rd_q == PtrW'(OutFifoDepth - 1)) ? '0 : rd_q + 1'b1;
          cnt_q <= cnt_q + CntW'(hs) - CntW'(pop);
        end
      end

      // FIFO storage, written on push
      always_ff @(posedge clk_i) begin
        if (hs && !flush_i) begin
          mem_q[wr_q]     <= data_i[sel];
          idx_mem_q[wr_q] <= sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_mcast_xbar.sv
// Bench for stream_mcast_xbar: a vector table drives a 3x4 bypass instance,
// a hand-written sequence with a scoreboard drives a 3x4 depth-2 instance.
module tb_stream_mcast_xbar;

  localparam int NI = 3;
  localparam int NO = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;

  logic [NI-1:0][DW-1:0] d0_data;
  logic [NI-1:0][NO-1:0] d0_mask;
  logic [NI-1:0]         d0_valid, d0_ready;
  logic [NO-1:0][DW-1:0] d0_dout;
  logic [NO-1:0][1:0]    d0_idx;
  logic [NO-1:0]         d0_vout, d0_rdy_i;
  logic                  d0_flush;

  logic [NI-1:0][DW-1:0] d2_data;
  logic [NI-1:0][NO-1:0] d2_mask;
  logic [NI-1:0]         d2_valid, d2_ready;
  logic [NO-1:0][DW-1:0] d2_dout;
  logic [NO-1:0][1:0]    d2_idx;
  logic [NO-1:0]         d2_vout, d2_rdy_i;
  logic                  d2_flush;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  stream_mcast_xbar #(.NumInp(NI), .NumOut(NO), .DataWidth(DW), .OutFifoDepth(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(d0_flush),
    .data_i(d0_data), .mask_i(d0_mask), .valid_i(d0_valid), .ready_o(d0_ready),
    .data_o(d0_dout), .idx_o(d0_idx), .valid_o(d0_vout), .ready_i(d0_rdy_i)
  );

  stream_mcast_xbar #(.NumInp(NI), .NumOut(NO), .DataWidth(DW), .OutFifoDepth(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .flush_i(d2_flush),
    .data_i(d2_data), .mask_i(d2_mask), .valid_i(d2_valid), .ready_o(d2_ready),
    .data_o(d2_dout), .idx_o(d2_idx), .valid_o(d2_vout), .ready_i(d2_rdy_i)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic       flush;
    logic [2:0] vld;
    logic [3:0] m0, m1, m2;
    logic [7:0] a0, a1, a2;
    logic [3:0] rdy;
    logic [3:0] vo;
    logic [2:0] ro;
    logic [1:0] i0;
    logic [7:0] x0;
    logic [1:0] i1;
    logic [7:0] x1;
  } vec_t;

  vec_t tbl [23];

  // Scoreboard for the depth-2 instance, output 3: {idx, data}
  logic [33:0] sb [$];
  logic        sb_on = 1'b0;

  always @(negedge clk) begin
    if (sb_on && d2_vout[3] && d2_rdy_i[3]) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_pop", d2_dout[3], 32'hFFFF_FFFF);
      end else begin
        check("sb_data", d2_dout[3], sb[0][31:0]);
        check("sb_idx", 32'(d2_idx[3]), 32'(sb[0][33:32]));
        void'(sb.pop_front());
      end
    end
  end

  task automatic step2(input logic [2:0] vld, input logic [3:0] rdy, input logic [2:0] ro,
                       input logic vo3, input logic [7:0] d3, input string tag);
    d2_valid = vld;
    d2_rdy_i = rdy;
    @(negedge clk);
    check({tag, "_ready_o"}, 32'(d2_ready), 32'(ro));
    check({tag, "_valid_o3"}, 32'(d2_vout[3]), 32'(vo3));
    check({tag, "_data_o3"}, d2_dout[3], 32'(d3));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //            fl  vld     m0       m1       m2       a0     a1     a2     rdy      vo       ro      i0 x0     i1 x1
    tbl[0]  = '{1'b0, 3'b000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 4'b1111, 4'b0000, 3'b000, 0, 8'h00, 0, 8'h00};
    tbl[1]  = '{1'b0, 3'b001, 4'b1111, 4'b0000, 4'b0000, 8'hA5, 8'h00, 8'h00, 4'b1111, 4'b1111, 3'b001, 0, 8'hA5, 0, 8'hA5};
    tbl[2]  = '{1'b1, 3'b000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 4'b1111, 4'b0000, 3'b000, 0, 8'h00, 0, 8'h00};
    tbl[3]  = '{1'b0, 3'b001, 4'b0011, 4'b0000, 4'b0000, 8'h11, 8'h00, 8'h00, 4'b0001, 4'b0011, 3'b000, 0, 8'h11, 0, 8'h11};
    tbl[4]  = '{1'b0, 3'b001, 4'b0011, 4'b0000, 4'b0000, 8'h11, 8'h00, 8'h00, 4'b0001, 4'b0010, 3'b000, 0, 8'h00, 0, 8'h11};
    tbl[5]  = '{1'b0, 3'b001, 4'b0011, 4'b0000, 4'b0000, 8'h11, 8'h00, 8'h00, 4'b0011, 4'b0010, 3'b001, 0, 8'h00, 0, 8'h11};
    tbl[6]  = '{1'b1, 3'b000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 4'b1111, 4'b0000, 3'b000, 0, 8'h00, 0, 8'h00};
    tbl[7]  = '{1'b0, 3'b111, 4'b0001, 4'b0001, 4'b0001, 8'h30, 8'h31, 8'h32, 4'b0001, 4'b0001, 3'b001, 0, 8'h30, 0, 8'h00};
    tbl[8]  = '{1'b0, 3'b111, 4'b0001, 4'b0001, 4'b0001, 8'h30, 8'h31, 8'h32, 4'b0001, 4'b0001, 3'b010, 1, 8'h31, 0, 8'h00};
    tbl[9]  = '{1'b0, 3'b111, 4'b0001, 4'b0001, 4'b0001, 8'h30, 8'h31, 8'h32, 4'b0001, 4'b0001, 3'b100, 2, 8'h32, 0, 8'h00};
    tbl[10] = '{1'b0, 3'b111, 4'b0001, 4'b0001, 4'b0001, 8'h30, 8'h31, 8'h32, 4'b0001, 4'b0001, 3'b001, 0, 8'h30, 0, 8'h00};
    tbl[11] = '{1'b1, 3'b000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 4'b1111, 4'b0000, 3'b000, 0, 8'h00, 0, 8'h00};
    tbl[12] = '{1'b0, 3'b110, 4'b0000, 4'b0001, 4'b0001, 8'h40, 8'h41, 8'h42, 4'b0000, 4'b0001, 3'b000, 1, 8'h41, 0, 8'h00};
    tbl[13] = '{1'b0, 3'b111, 4'b0001, 4'b0001, 4'b0001, 8'h40, 8'h41, 8'h42, 4'b0000, 4'b0001, 3'b000, 1, 8'h41, 0, 8'h00};
    tbl[14] = '{1'b0, 3'b111, 4'b0001, 4'b0001, 4'b0001, 8'h40, 8'h41, 8'h42, 4'b0000, 4'b0001, 3'b000, 1, 8'h41, 0, 8'h00};
    tbl[15] = '{1'b0, 3'b111, 4'b0001, 4'b0001, 4'b0001, 8'h40, 8'h41, 8'h42, 4'b0001, 4'b0001, 3'b010, 1, 8'h41, 0, 8'h00};
    tbl[16] = '{1'b0, 3'b101, 4'b0001, 4'b0001, 4'b0001, 8'h40, 8'h41, 8'h42, 4'b0001, 4'b0001, 3'b100, 2, 8'h42, 0, 8'h00};
    tbl[17] = '{1'b0, 3'b001, 4'b0001, 4'b0001, 4'b0001, 8'h40, 8'h41, 8'h42, 4'b0001, 4'b0001, 3'b001, 0, 8'h40, 0, 8'h00};
    tbl[18] = '{1'b0, 3'b001, 4'b0000, 4'b0000, 4'b0000, 8'h55, 8'h00, 8'h00, 4'b1111, 4'b0000, 3'b001, 0, 8'h00, 0, 8'h00};
    tbl[19] = '{1'b0, 3'b001, 4'b0011, 4'b0000, 4'b0000, 8'h66, 8'h00, 8'h00, 4'b0001, 4'b0011, 3'b000, 0, 8'h66, 0, 8'h66};
    tbl[20] = '{1'b1, 3'b000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 4'b0001, 4'b0000, 3'b000, 0, 8'h00, 0, 8'h00};
    tbl[21] = '{1'b0, 3'b011, 4'b0011, 4'b0001, 4'b0000, 8'h66, 8'h67, 8'h00, 4'b0011, 4'b0011, 3'b001, 0, 8'h66, 0, 8'h66};
    tbl[22] = '{1'b1, 3'b000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 4'b1111, 4'b0000, 3'b000, 0, 8'h00, 0, 8'h00};

    rst      = 1'b1;
    d0_flush = 1'b0;
    d0_data  = '0;
    d0_mask  = '0;
    d0_valid = '0;
    d0_rdy_i = '1;
    d2_flush = 1'b0;
    d2_data  = '0;
    d2_mask  = '0;
    d2_valid = '0;
    d2_rdy_i = '0;

    // Reset state while reset is held
    @(negedge clk);
    check("rst_valid_o_d0", 32'(d0_vout), 32'h0);
    check("rst_ready_o_d0", 32'(d0_ready), 32'h0);
    check("rst_data_o0_d0", d0_dout[0], 32'h0);
    check("rst_valid_o_d2", 32'(d2_vout), 32'h0);
    check("rst_data_o3_d2", d2_dout[3], 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Table-driven sequence on the bypass instance
    for (int r = 0; r < 23; r++) begin
      d0_flush   = tbl[r].flush;
      d0_valid   = tbl[r].vld;
      d0_mask[0] = tbl[r].m0;
      d0_mask[1] = tbl[r].m1;
      d0_mask[2] = tbl[r].m2;
      d0_data[0] = 32'(tbl[r].a0);
      d0_data[1] = 32'(tbl[r].a1);
      d0_data[2] = 32'(tbl[r].a2);
      d0_rdy_i   = tbl[r].rdy;
      @(negedge clk);
      check($sformatf("row%0d_valid_o", r), 32'(d0_vout), 32'(tbl[r].vo));
      check($sformatf("row%0d_ready_o", r), 32'(d0_ready), 32'(tbl[r].ro));
      check($sformatf("row%0d_idx_o0", r), 32'(d0_idx[0]), 32'(tbl[r].i0));
      check($sformatf("row%0d_data_o0", r), d0_dout[0], 32'(tbl[r].x0));
      check($sformatf("row%0d_idx_o1", r), 32'(d0_idx[1]), 32'(tbl[r].i1));
      check($sformatf("row%0d_data_o1", r), d0_dout[1], 32'(tbl[r].x1));
      @(posedge clk);
      #1;
    end
    d0_flush = 1'b0;
    d0_valid = '0;

    // Depth-2 FIFO: three beats to output 3 with the output stalled
    d2_data[0] = 32'hB0;
    d2_data[1] = 32'hB1;
    d2_data[2] = 32'hB2;
    d2_mask[0] = 4'b1000;
    d2_mask[1] = 4'b1000;
    d2_mask[2] = 4'b1000;
    sb.push_back({2'd0, 32'hB0});
    sb.push_back({2'd1, 32'hB1});
    sb.push_back({2'd2, 32'hB2});
    sb_on = 1'b1;
    step2(3'b111, 4'b0000, 3'b001, 1'b0, 8'h00, "f_push0");
    step2(3'b110, 4'b0000, 3'b010, 1'b1, 8'hB0, "f_push1");
    step2(3'b100, 4'b0000, 3'b000, 1'b1, 8'hB0, "f_full0");
    step2(3'b100, 4'b0000, 3'b000, 1'b1, 8'hB0, "f_full1");
    step2(3'b100, 4'b1000, 3'b100, 1'b1, 8'hB0, "f_popush");
    step2(3'b000, 4'b1000, 3'b000, 1'b1, 8'hB1, "f_drain1");
    step2(3'b000, 4'b1000, 3'b000, 1'b1, 8'hB2, "f_drain2");
    step2(3'b000, 4'b1000, 3'b000, 1'b0, 8'h00, "f_empty");
    sb_on = 1'b0;
    check("sb_remaining", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_mcast_xbar.md
Name: stream_mcast_xbar

Overview:
Fully connected stream crossbar with multicast: each input beat carries a one-hot-or-more output mask and is delivered to every selected output before the input handshake completes. Each output has its own round-robin arbiter with lock-in and an optional output FIFO. It is the multicast successor of the unicast stream crossbar and sits between DMA/cluster request sources and multiple target ports.

Parameters:
NumInp, 2, number of inputs (>0)
NumOut, 2, number of outputs (>0)
DataWidth, 32, payload width when payload_t is not overridden
payload_t, logic [DataWidth-1:0], payload type
OutFifoDepth, 0, per-output FIFO depth; 0 = combinational bypass
IdxWidth, derived: NumInp>1 ? $clog2(NumInp) : 1, do not override

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
flush_i  in  1  clears arbiter, lock, served and FIFO state
data_i  in  NumInp x payload_t  input payloads
mask_i  in  NumInp x NumOut  output selection mask per input
valid_i  in  NumInp  input valid
ready_o  out  NumInp  input beat fully delivered
data_o  out  NumOut x payload_t  output payloads
idx_o  out  NumOut x IdxWidth  source input index
valid_o  out  NumOut  output valid
ready_i  in  NumOut  output ready

Behaviour:
- Reset (rst_i=1, async): served[i][j]=0, lock[j]=0, rr pointer[j]=0, FIFOs empty; valid_o=0, ready_o=0 for nonzero masks, data_o/idx_o=0.
- Input rules: data_i and mask_i stable while valid_i && !ready_o; valid_i must not drop before ready_o.
- served[i][j]: output j has already taken input i's current beat.
- Request to output j from input i: valid_i[i] & mask_i[i][j] & !served[i][j].
- Arbiter j: round robin. Without lock, picks the first requesting index at or after pointer[j], wrapping. On output-side handshake with input k: pointer[j] <= (k+1) mod NumInp, set served[k][j]. If arbiter valid but not accepted: lock[j]=1 and the chosen index is held until handshake (AXI-stable output). A held index is always still requesting because inputs are stable.
- ready_o[i] = valid_i[i] & (for all j: !mask_i[i][j] | served[i][j] | take[i][j] this cycle). On ready_o[i]: clear served[i][*] (takes precedence over set).
- Zero mask with valid: ready_o=1 same cycle, beat discarded.
- OutFifoDepth=0: output path combinational, data_o = selected data_i, 0-cycle latency; ready_o can depend combinationally on ready_i.
- OutFifoDepth>0: arbiter handshake = FIFO push when not full; valid_o the cycle after push (1-cycle latency, no fall-through). Full: arbiter not accepted, lock holds. Push and pop in the same cycle when full: pop first, push accepted, depth stays full. Empty: valid_o=0.
- Different outputs progress independently; an input may be served by outputs in different cycles, and ready_o asserts in the cycle the last pending output takes it.
- flush_i (only legal with no valid_i): synchronously clears served, lock, pointers and FIFOs next edge; flush has priority over simultaneous push.
- Reset mid-operation: all partial multicast state is lost; inputs re-present the beat after reset.

Test Plan:
- NumInp=3, NumOut=4, depth 0: in0 data 0xA5 mask 0b1111, all ready_i=1 -> valid_o=0b1111, every data_o=0xA5, idx_o=0, ready_o[0]=1 same cycle.
- Partial delivery: in0 mask 0b0011, ready_i=0b0001 for 2 cycles then 0b0011 -> out0 takes in cycle 0, out0 not re-sent, ready_o[0] only in cycle 2.
- Contention: in0,in1,in2 all mask 0b0001, ready_i[0]=1 -> idx_o[0] order 0,1,2 over 3 cycles, then pointer wraps to 0.
- Lock-in: in1 and in2 request out0 with ready_i[0]=0 for 3 cycles while in0 raises -> idx_o[0] and data_o[0] stable at 1 until handshake.
- Depth 2: 3 beats to out3, ready_i[3]=0 -> 2 pushed, third stalls, valid_o[3] cycle after first push; release ready -> FIFO order preserved.
- Zero mask -> ready_o=1, no valid_o; flush_i after partial served -> served cleared, pointers reset to 0.
